// File: rtl/ctrl_trace.sv
// ctrl_trace: samples control-unit signals each cycle into an 8-entry FWFT record FIFO;
// define TRACE_RLE_EN to compile in run-length compression of repeated samples.
module ctrl_trace (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        zero,
    input  logic        s_inc,
    input  logic        s_inm,
    input  logic        we,
    input  logic        wez,
    input  logic [2:0]  AluOp,
    input  logic        trace_en,
    output logic        rec_valid,
    output logic [17:0] rec_data,
    input  logic        rec_ready,
    output logic        overflow,
    output logic [3:0]  fifo_count
);
    logic [13:0] s_word;
    logic        push;
    logic [17:0] push_data;
    logic [17:0] mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic        pop;
    logic        wr;

    assign s_word = {Opcode, AluOp, wez, we, s_inm, s_inc, zero};

`ifdef TRACE_RLE_EN
    logic [3:0]  hold_cnt;
    logic [13:0] hold_word;
    logic        hold_busy;

    assign hold_busy = hold_cnt != 4'd0;
    assign push      = hold_busy && (!trace_en || s_word != hold_word || hold_cnt == 4'd15);
    assign push_data = {hold_cnt, hold_word};

    // Extend the current run, or close it and start a new one; trace_en low flushes the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= 4'd0;
            hold_word <= 14'd0;
        end else if (trace_en) begin
            if (push || !hold_busy) begin
                hold_word <= s_word;
                hold_cnt  <= 4'd1;
            end else begin
                hold_cnt  <= hold_cnt + 4'd1;
            end
        end else begin
            hold_cnt <= 4'd0;
        end
    end
`else
    assign push      = trace_en;
    assign push_data = {4'd1, s_word};
`endif

    assign rec_valid = fifo_count != 4'd0;
    assign rec_data  = rec_valid ? mem[rd_ptr] : 18'd0;
    assign pop       = rec_valid && rec_ready;
    assign wr        = push && (fifo_count != 4'd8 || pop);

    // Record storage; a full FIFO may still accept a write when the head leaves on the same edge
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= push_data;
    end

    // Pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= 3'd0;
            rd_ptr     <= 3'd0;
            fifo_count <= 4'd0;
            overflow   <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 3'd1;
            if (pop)
                rd_ptr <= rd_ptr + 3'd1;
            fifo_count <= fifo_count + 4'(wr) - 4'(pop);
            overflow   <= overflow | (push && !wr);
        end
    end
endmodule

// File: tb/tb_ctrl_trace.sv
// tb_ctrl_trace: scoreboard bench for ctrl_trace, covering both the plain and TRACE_RLE_EN builds.
module tb_ctrl_trace;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Opcode = '0;
    logic        zero = 1'b0;
    logic        s_inc = 1'b0;
    logic        s_inm = 1'b0;
    logic        we = 1'b0;
    logic        wez = 1'b0;
    logic [2:0]  AluOp = '0;
    logic        trace_en = 1'b0;
    logic        rec_valid;
    logic [17:0] rec_data;
    logic        rec_ready = 1'b0;
    logic        overflow;
    logic [3:0]  fifo_count;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [17:0] exp_q [$];
    logic [17:0] e;

`ifdef TRACE_RLE_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    ctrl_trace dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .s_inc(s_inc), .s_inm(s_inm),
        .we(we), .wez(wez), .AluOp(AluOp), .trace_en(trace_en), .rec_valid(rec_valid),
        .rec_data(rec_data), .rec_ready(rec_ready), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] rec(input logic [3:0] c, input logic [5:0] op,
                                        input logic [2:0] alu, input logic [4:0] f);
        return {c, op, alu, f};
    endfunction

    task automatic step(input logic [5:0] op, input logic [2:0] alu, input logic [4:0] f,
                        input logic en, input logic rdy);
        @(negedge clk);
        Opcode = op;
        AluOp = alu;
        {wez, we, s_inm, s_inc, zero} = f;
        trace_en = en;
        rec_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        trace_en = 1'b0;
        rec_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rec_valid); end
        n_chk++; if (rec_data !== 18'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rec_data); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        for (int i = 0; i < 3 + LAG; i++)
            step(6'h10 + 6'(i), 3'(i), 5'h0A, 1'b1, 1'b0);
        n_chk++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 3", fifo_count); end
        #2 reset = 1'b1;
        #1;
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL midrun_reset_count: got %0d want 0", fifo_count); end
        n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_valid: got %b want 0", rec_valid); end
        n_chk++; if (rec_data !== 18'd0) begin n_fail++; $display("FAIL midrun_reset_data: got %h want 0", rec_data); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_ovf: got %b want 0", overflow); end
        @(negedge clk);
        trace_en = 1'b0;
        reset = 1'b0;
        step(6'h00, 3'd0, 5'h00, 1'b0, 1'b1);
        n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_flush: got valid %b want 0", rec_valid); end
    endtask

`ifndef TRACE_RLE_EN
    task automatic test_no_rle;
        logic [5:0] ops [3];
        ops = '{6'h02, 6'h03, 6'h02};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(ops[i], 3'd1, 5'h00, 1'b1, 1'b1);
            exp_q.push_back(rec(4'd1, ops[i], 3'd1, 5'h00));
            n_chk++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL norle_valid%0d: got %b want 1", i, rec_valid); end
            e = exp_q.pop_front();
            n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL norle_rec%0d: got %h want %h", i, rec_data, e); end
        end
        step(6'h3F, 3'd7, 5'h1F, 1'b0, 1'b1);
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL norle_idle_count: got %0d want 0", fifo_count); end
        n_chk++; if (rec_data !== 18'd0) begin n_fail++; $display("FAIL norle_idle_data: got %h want 0", rec_data); end
    endtask
`else
    task automatic test_rle_run;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(6'h2A, 3'd5, 5'h13, 1'b1, 1'b0);
            n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL rle_run_early%0d: got valid %b want 0", i, rec_valid); end
        end
        step(6'h00, 3'd0, 5'h00, 1'b0, 1'b0);
        n_chk++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL rle_run_count: got %0d want 1", fifo_count); end
        e = rec(4'd5, 6'h2A, 3'd5, 5'h13);
        n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL rle_run_rec: got %h want %h", rec_data, e); end
    endtask

    task automatic test_rle_sat;
        do_reset();
        for (int i = 0; i < 17; i++)
            step(6'h11, 3'd2, 5'h05, 1'b1, 1'b0);
        step(6'h00, 3'd0, 5'h00, 1'b0, 1'b0);
        n_chk++; if (fifo_count !== 4'd2) begin n_fail++; $display("FAIL rle_sat_count: got %0d want 2", fifo_count); end
        e = rec(4'd15, 6'h11, 3'd2, 5'h05);
        n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL rle_sat_first: got %h want %h", rec_data, e); end
        step(6'h00, 3'd0, 5'h00, 1'b0, 1'b1);
        e = rec(4'd2, 6'h11, 3'd2, 5'h05);
        n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL rle_sat_second: got %h want %h", rec_data, e); end
        step(6'h00, 3'd0, 5'h00, 1'b0, 1'b1);
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rle_sat_empty: got %0d want 0", fifo_count); end
    endtask
`endif

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(6'h20 + 6'(i), 3'(i), 5'(i + 7), 1'b1, 1'b0);
            if (i < 8)
                exp_q.push_back(rec(4'd1, 6'h20 + 6'(i), 3'(i), 5'(i + 7)));
        end
        step(6'h00, 3'd0, 5'h00, 1'b0, 1'b0);
        n_chk++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", fifo_count); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %b want 1", overflow); end
        n_chk++; if (rec_data !== exp_q[0]) begin n_fail++; $display("FAIL full_head: got %h want %h", rec_data, exp_q[0]); end
        for (int k = 0; k < 16 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL full_drain%0d: got %h want %h", k, rec_data, e); end
            step(6'h00, 3'd0, 5'h00, 1'b0, 1'b1);
        end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", fifo_count); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        step(6'h00, 3'd0, 5'h00, 1'b0, 1'b1);
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d want 0", fifo_count); end
        n_chk++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b want 0", rec_valid); end
    endtask

    task automatic test_simul;
        do_reset();
        for (int i = 0; i < 8 + LAG; i++) begin
            step(6'h30 + 6'(i), 3'(i), 5'(i + 3), 1'b1, 1'b0);
            if (i < 8)
                exp_q.push_back(rec(4'd1, 6'h30 + 6'(i), 3'(i), 5'(i + 3)));
        end
        n_chk++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL simul_fill: got %0d want 8", fifo_count); end
        step(6'h30 + 6'(8 + LAG), 3'(8 + LAG), 5'(11 + LAG), 1'b1, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(rec(4'd1, 6'h38, 3'd0, 5'd11));
`ifdef TRACE_RLE_EN
        exp_q.push_back(rec(4'd1, 6'h39, 3'd1, 5'd12));
`endif
        n_chk++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL simul_count: got %0d want 8", fifo_count); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf: got %b want 0", overflow); end
        for (int k = 0; k < 16 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL simul_drain%0d: got %h want %h", k, rec_data, e); end
            step(6'h00, 3'd0, 5'h00, 1'b0, 1'b1);
        end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL simul_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] alu;
        logic [4:0] f;
        logic [17:0] prev;
        logic        r;
        do_reset();
        prev = '0;
        for (int i = 0; i < 24; i++) begin
            r = (i % 4) != 0;
            alu = 3'($urandom_range(0, 7));
            f = 5'($urandom_range(0, 31));
            if (rec_valid && r) begin
                e = exp_q.pop_front();
                n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL b2b_rec%0d: got %h want %h", i, rec_data, e); end
            end
`ifdef TRACE_RLE_EN
            if (i > 0)
                exp_q.push_back(prev);
`else
            exp_q.push_back(rec(4'd1, 6'(i), alu, f));
`endif
            prev = rec(4'd1, 6'(i), alu, f);
            step(6'(i), alu, f, 1'b1, r);
        end
`ifdef TRACE_RLE_EN
        exp_q.push_back(prev);
`endif
        for (int k = 0; k < 16 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_chk++; if (rec_data !== e) begin n_fail++; $display("FAIL b2b_drain%0d: got %h want %h", k, rec_data, e); end
            step(6'h00, 3'd0, 5'h00, 1'b0, 1'b1);
        end
        n_chk++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", fifo_count); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
`ifndef TRACE_RLE_EN
        test_no_rle();
`else
        test_rle_run();
        test_rle_sat();
`endif
        test_full();
        test_simul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_trace.md
CTRL_TRACE -- requirements
Module: ctrl_trace

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port Opcode, input, 6 bits: opcode of the current cycle, as presented to the control unit.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag of the current cycle.
REQ-005 SHALL have ports s_inc, s_inm, we and wez, each input, 1 bit: control-unit outputs of the current cycle.
REQ-006 SHALL have port AluOp, input, 3 bits: ALU operation of the current cycle.
REQ-007 SHALL have port trace_en, input, 1 bit: 1 = sample each cycle.
REQ-008 SHALL have port rec_valid, output, 1 bit: a record is available.
REQ-009 SHALL have port rec_data, output, 18 bits: the head record.
REQ-010 SHALL have port rec_ready, input, 1 bit: the consumer accepts the record.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag meaning a record was dropped.
REQ-012 SHALL have port fifo_count, output, 4 bits: occupancy, range 0..8.

Function
REQ-013 Sample word S SHALL be {Opcode, AluOp, wez, we, s_inm, s_inc, zero}, 14 bits.
REQ-014 The record format SHALL be rec_data[17:14] = repeat count (1..15) and rec_data[13:0] = S.
REQ-015 Output buffer SHALL be an 8-entry first-word-fall-through FIFO.
- rec_valid = (fifo_count != 0).
- rec_data = head entry when rec_valid = 1, else 0.
REQ-016 Pop SHALL occur on a rising edge with rec_valid = 1 and rec_ready = 1.
- rec_data SHALL stay stable while rec_valid = 1 and rec_ready = 0.
REQ-017 A push while full without a same-edge pop SHALL drop the record, set overflow to 1 and leave the FIFO contents unchanged.
REQ-018 A push and a pop on the same edge SHALL both take effect, including when full; fifo_count stays unchanged.
REQ-019 A pop with rec_valid = 0 SHALL have no effect; fifo_count SHALL never wrap below 0 or above 8.
REQ-020 overflow SHALL be cleared only by reset.
REQ-021 Compression behaviour SHALL follow the Configuration section (REQ-027..REQ-029).
REQ-022 trace_en = 0 on an edge SHALL sample nothing.
REQ-023 Outputs SHALL update only on the clk rising edge (or on reset); there SHALL be no combinational path from the sample inputs to rec_data.

Reset
REQ-024 While reset = 1 the block SHALL immediately enter and hold the reset state.
- FIFO empty; fifo_count = 0, rec_valid = 0, rec_data = 0, overflow = 0.
- Hold counter = 0; hold word = 0.
REQ-025 Reset asserted mid-run SHALL discard any pending hold record and all FIFO entries, with no flush.
REQ-026 Sampling SHALL resume on the first rising edge after reset deasserts, if trace_en = 1.

Configuration
REQ-027 Compression SHALL be compiled in only when macro TRACE_RLE_EN is defined.
REQ-028 With TRACE_RLE_EN defined, run-length compression SHALL apply on each edge with trace_en = 1:
- Hold counter = 0: load the hold word with S, hold counter = 1, no push.
- S equals the hold word and hold counter < 15: hold counter increments, no push.
- S differs from the hold word, or hold counter = 15: push {hold counter, hold word}, reload the hold word with S, hold counter = 1.
- On an edge with trace_en = 0 and hold counter != 0: push the held record (flush), hold counter = 0.
- Latency: a run becomes visible one edge after its last matching sample, at the first edge of the mismatch, saturation or flush.
REQ-029 Without TRACE_RLE_EN, no hold register SHALL exist:
- Each edge with trace_en = 1 pushes {4'd1, S} directly.
- rec_valid rises after the same edge if the FIFO was empty.
- trace_en = 0 only stops pushing.

Verification
REQ-030 Reset check: assert reset mid-run with 3 entries queued -> fifo_count = 0, rec_valid = 0 and overflow = 0 immediately, before the next clk edge.
REQ-031 No RLE, 3 cycles with Opcode = 6'h02, 6'h03, 6'h02, AluOp = 3'd1, rec_ready = 1 -> three records, each with count field = 1, in order.
REQ-032 RLE, S constant for 5 cycles, then trace_en = 0 -> one record with count = 5, appearing after the trace_en = 0 edge.
REQ-033 RLE, S constant for 17 cycles, then flush -> records with count = 15, then count = 2.
REQ-034 Full FIFO: rec_ready = 0 and 9 distinct records pushed -> fifo_count = 8, overflow = 1, head record = the first pushed.
REQ-035 Simultaneous push and pop: FIFO full with rec_ready = 1 and a new push -> fifo_count stays 8, overflow stays 0, the new record becomes the tail.
